// File: rtl/nmi_pkg.sv
// Shared types and constants for the NMI address router.
// State encoding and error codes used by nmi_router and its decoder.
package nmi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    RESP,
    ERR
  } nmi_rt_state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_UNMAP = 2'd1;
  localparam logic [1:0] ERR_TMO   = 2'd2;

endpackage

// File: rtl/nmi_addr_dec.sv
// Combinational base/mask address decoder for the NMI router.
// Produces a one-hot slave select; on overlapping windows the lowest index wins.
module nmi_addr_dec
  import nmi_pkg::*;
#(
  parameter int unsigned        NSLV     = 4,
  parameter int unsigned        AW       = 32,
  parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
  parameter logic [NSLV*AW-1:0] SLV_MASK = '0
) (
  input  logic [AW-1:0]   i_addr,
  output logic [NSLV-1:0] o_sel,
  output logic            o_hit
);

  always_comb begin
    o_sel = '0;
    o_hit = 1'b0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (!o_hit && ((i_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
        o_sel[i] = 1'b1;
        o_hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nmi_router.sv
// 1-to-NSLV native-memory-interface router with base/mask decode,
// per-transaction timeout watchdog and sticky first-error capture with IRQ.
module nmi_router
  import nmi_pkg::*;
#(
  parameter int unsigned        NSLV        = 4,
  parameter int unsigned        AW          = 32,
  parameter int unsigned        DW          = 32,
  parameter logic [NSLV*AW-1:0] SLV_BASE    = '0,
  parameter logic [NSLV*AW-1:0] SLV_MASK    = '0,
  parameter int unsigned        TIMEOUT_CYC = 1024,
  parameter logic [DW-1:0]      ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 mstr_valid_i,
  input  logic [AW-1:0]        mstr_addr_i,
  input  logic [DW-1:0]        mstr_wdata_i,
  input  logic [DW/8-1:0]      mstr_wstrb_i,
  output logic [DW-1:0]        mstr_rdata_o,
  output logic                 mstr_ready_o,
  output logic [NSLV-1:0]      slv_valid_o,
  output logic [AW-1:0]        slv_addr_o,
  output logic [DW-1:0]        slv_wdata_o,
  output logic [DW/8-1:0]      slv_wstrb_o,
  input  logic [NSLV*DW-1:0]   slv_rdata_i,
  input  logic [NSLV-1:0]      slv_ready_i,
  output logic                 err_irq_o,
  output logic [AW-1:0]        err_addr_o,
  output logic [1:0]           err_code_o,
  input  logic                 err_clr_i
);

  localparam int unsigned    SW      = DW / 8;
  localparam int unsigned    CW      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0]  TMO_VAL = CW'(TIMEOUT_CYC);

  nmi_rt_state_e   r_state;
  logic [NSLV-1:0] r_slv_valid;
  logic [AW-1:0]   r_slv_addr;
  logic [DW-1:0]   r_slv_wdata;
  logic [SW-1:0]   r_slv_wstrb;
  logic [DW-1:0]   r_rdata;
  logic [DW-1:0]   r_mstr_rdata;
  logic            r_mstr_ready;
  logic [CW-1:0]   r_cnt;
  logic            r_err_irq;
  logic [AW-1:0]   r_err_addr;
  logic [1:0]      r_err_code;

  logic [NSLV-1:0] w_dec_sel;
  logic            w_dec_hit;
  logic [DW-1:0]   w_slv_rdata;
  logic            w_slv_ready;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_tmo;
  logic            w_accept;
  logic            w_err_unmap;
  logic            w_err_tmo;

  nmi_addr_dec #(
    .NSLV     (NSLV),
    .AW       (AW),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .i_addr (mstr_addr_i),
    .o_sel  (w_dec_sel),
    .o_hit  (w_dec_hit)
  );

  // In FWD the valid vector doubles as the latched one-hot select.
  always_comb begin
    w_slv_rdata = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (r_slv_valid[i]) w_slv_rdata |= slv_rdata_i[i*DW +: DW];
    end
  end

  assign w_slv_ready = |(slv_ready_i & r_slv_valid);
  assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
  assign w_tmo       = (TIMEOUT_CYC != 0) && (w_cnt_inc == TMO_VAL);
  // The cycle that shows mstr_ready_o still carries the old request's valid.
  assign w_accept    = (r_state == IDLE) && mstr_valid_i && !r_mstr_ready;
  assign w_err_unmap = w_accept && !w_dec_hit;
  assign w_err_tmo   = (r_state == FWD) && !w_slv_ready && w_tmo;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= IDLE;
      r_slv_valid  <= '0;
      r_slv_addr   <= '0;
      r_slv_wdata  <= '0;
      r_slv_wstrb  <= '0;
      r_rdata      <= '0;
      r_mstr_rdata <= '0;
      r_mstr_ready <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_mstr_ready <= 1'b0;
      r_mstr_rdata <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_slv_addr  <= mstr_addr_i;
            r_slv_wdata <= mstr_wdata_i;
            r_slv_wstrb <= mstr_wstrb_i;
            if (w_dec_hit) begin
              r_slv_valid <= w_dec_sel;
              r_cnt       <= '0;
              r_state     <= FWD;
            end else begin
              r_state <= ERR;
            end
          end
        end
        FWD: begin
          if (w_slv_ready) begin
            r_rdata     <= (r_slv_wstrb == '0) ? w_slv_rdata : '0;
            r_slv_valid <= '0;
            r_state     <= RESP;
          end else if (w_tmo) begin
            r_slv_valid <= '0;
            r_state     <= ERR;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        RESP: begin
          r_mstr_ready <= 1'b1;
          r_mstr_rdata <= r_rdata;
          r_state      <= IDLE;
        end
        ERR: begin
          r_mstr_ready <= 1'b1;
          r_mstr_rdata <= ERR_RDATA;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // First error is sticky; a clear coinciding with a new error keeps the new one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err_irq  <= 1'b0;
      r_err_addr <= '0;
      r_err_code <= ERR_NONE;
    end else if ((w_err_unmap || w_err_tmo) && ((r_err_code == ERR_NONE) || err_clr_i)) begin
      r_err_irq  <= 1'b1;
      r_err_addr <= w_err_unmap ? mstr_addr_i : r_slv_addr;
      r_err_code <= w_err_unmap ? ERR_UNMAP : ERR_TMO;
    end else if (err_clr_i) begin
      r_err_irq  <= 1'b0;
      r_err_code <= ERR_NONE;
    end
  end

  assign mstr_rdata_o = r_mstr_rdata;
  assign mstr_ready_o = r_mstr_ready;
  assign slv_valid_o  = r_slv_valid;
  assign slv_addr_o   = r_slv_addr;
  assign slv_wdata_o  = r_slv_wdata;
  assign slv_wstrb_o  = r_slv_wstrb;
  assign err_irq_o    = r_err_irq;
  assign err_addr_o   = r_err_addr;
  assign err_code_o   = r_err_code;

endmodule
